barrel_unshifter: RTL and testbench

BARREL_UNSHIFTER -- requirements
Module: barrel_unshifter

---
 rtl/barrel_unshifter.sv | 145 ++++++++++++++
 tb/tb_barrel_unshifter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/barrel_unshifter.sv
// Pipelined inverse barrel shifter: undoes a per-group lane rotation across NOF_PES lanes,
// one power-of-two rotation level per pipeline stage, with valid/ready flow control.
module barrel_unshifter #(
  parameter int WORD_SIZE        = 256,
  parameter int NOF_PES          = 16,
  parameter int NOF_LEVELS       = $clog2(NOF_PES),
  parameter int GROUP_SIZE_WIDTH = NOF_LEVELS + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WORD_SIZE*NOF_PES-1:0]  in,
  input  logic [NOF_LEVELS-1:0]         shift,
  input  logic [GROUP_SIZE_WIDTH-1:0]   group_size,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WORD_SIZE*NOF_PES-1:0]  out,
  output logic                          err
);

  typedef logic [NOF_PES-1:0][WORD_SIZE-1:0] word_t;
  typedef logic [NOF_LEVELS-1:0]             lane_idx_t;
  typedef logic [GROUP_SIZE_WIDTH-1:0]       gsize_t;

  localparam gsize_t MAX_GROUP = gsize_t'(NOF_PES);

  // Lane i takes lane base + ((i - base + 2^k) mod G); only applies when 2^k < G.
  function automatic word_t rotate_stage(input word_t d, input logic sh_bit,
                                         input gsize_t gs, input int k);
    word_t     r;
    lane_idx_t mask;
    lane_idx_t amt;
    lane_idx_t base;
    lane_idx_t idx;
    lane_idx_t src;
    r    = '0;
    mask = lane_idx_t'(gs - gsize_t'(1));
    amt  = '0;
    if (sh_bit && ((1 << k) < int'(gs))) begin
      amt = lane_idx_t'(1 << k);
    end
    for (int i = 0; i < NOF_PES; i++) begin
      idx  = lane_idx_t'(i);
      base = idx & ~mask;
      src  = base + ((idx - base + amt) & mask);
      r[i] = d[src];
    end
    return r;
  endfunction

  logic   group_legal;
  gsize_t group_eff;
  logic   advance;
  logic   err_d;
  logic   err_q;

  word_t     stage_data  [NOF_LEVELS];
  logic      stage_valid [NOF_LEVELS];
  lane_idx_t stage_shift [NOF_LEVELS];
  gsize_t    stage_gsize [NOF_LEVELS];

  // Anything other than a power of two up to NOF_PES falls back to one full-width group.
  always_comb begin
    group_legal = (group_size != '0) &&
                  ((group_size & (group_size - gsize_t'(1))) == '0) &&
                  (group_size <= MAX_GROUP);
    group_eff   = group_legal ? group_size : MAX_GROUP;
    advance     = out_ready || !stage_valid[NOF_LEVELS-1];
    err_d       = in_valid && advance && !group_legal;
  end

  for (genvar k = 0; k < NOF_LEVELS; k++) begin : g_stage
    word_t     data_q;
    word_t     data_d;
    word_t     src_data;
    logic      valid_q;
    logic      valid_d;
    logic      src_valid;
    lane_idx_t shift_q;
    lane_idx_t shift_d;
    lane_idx_t src_shift;
    gsize_t    gsize_q;
    gsize_t    gsize_d;
    gsize_t    src_gsize;

    if (k == 0) begin : g_head
      assign src_data  = in;
      assign src_valid = in_valid;
      assign src_shift = shift;
      assign src_gsize = group_eff;
    end else begin : g_tail
      assign src_data  = stage_data[k-1];
      assign src_valid = stage_valid[k-1];
      assign src_shift = stage_shift[k-1];
      assign src_gsize = stage_gsize[k-1];
    end

    always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      shift_d = shift_q;
      gsize_d = gsize_q;
      if (advance) begin
        data_d  = rotate_stage(src_data, src_shift[k], src_gsize, k);
        valid_d = src_valid;
        shift_d = src_shift;
        gsize_d = src_gsize;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_q  <= '0;
        valid_q <= 1'b0;
        shift_q <= '0;
        gsize_q <= '0;
      end else begin
        data_q  <= data_d;
        valid_q <= valid_d;
        shift_q <= shift_d;
        gsize_q <= gsize_d;
      end
    end

    assign stage_data[k]  = data_q;
    assign stage_valid[k] = valid_q;
    assign stage_shift[k] = shift_q;
    assign stage_gsize[k] = gsize_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign in_ready  = advance;
  assign out       = stage_data[NOF_LEVELS-1];
  assign out_valid = stage_valid[NOF_LEVELS-1];
  assign err       = err_q;

endmodule

// File: tb/tb_barrel_unshifter.sv
// Directed self-checking bench for barrel_unshifter at 16 lanes x 256 bits.
module tb_barrel_unshifter;

  localparam int WS = 256;
  localparam int NP = 16;
  localparam int NL = 4;
  localparam int GW = 5;
  localparam logic [63:0] ID_NIB = 64'hFEDC_BA98_7654_3210;

  typedef logic [NP-1:0][WS-1:0] word_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WS*NP-1:0] in_w;
  logic [NL-1:0]    shift;
  logic [GW-1:0]    gsize;
  logic             out_valid;
  logic             out_ready;
  logic [WS*NP-1:0] out_w;
  logic             err;

  int checks   = 0;
  int failures = 0;

  barrel_unshifter #(
    .WORD_SIZE        (WS),
    .NOF_PES          (NP),
    .NOF_LEVELS       (NL),
    .GROUP_SIZE_WIDTH (GW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in         (in_w),
    .shift      (shift),
    .group_size (gsize),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (out_w),
    .err        (err)
  );

  always #5 clk = ~clk;

  // A small lane value is replicated across the whole lane so wide-bit faults show up.
  function automatic logic [WS-1:0] mk_lane(input logic [15:0] v);
    return {16{v ^ 16'hA5C0}};
  endfunction

  function automatic word_t mk_word(input logic [63:0] nib);
    word_t w;
    for (int j = 0; j < NP; j++) w[j] = mk_lane({12'h000, nib[j*4 +: 4]});
    return w;
  endfunction

  function automatic word_t stream_in(input int n);
    word_t w;
    for (int j = 0; j < NP; j++) w[j] = mk_lane(16'(n*16 + j));
    return w;
  endfunction

  function automatic word_t stream_exp(input int n);
    word_t w;
    for (int i = 0; i < NP; i++) w[i] = mk_lane(16'(n*16 + ((i + n) % NP)));
    return w;
  endfunction

  function automatic logic [127:0] lane_bytes(input word_t w);
    logic [127:0] r;
    for (int j = 0; j < NP; j++) r[j*8 +: 8] = w[j][7:0];
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_in;
    for (int j = 0; j < NP*WS/32; j++) in_w[j*32 +: 32] = $urandom();
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input word_t obs, input word_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed_lane_bytes=%h expected_lane_bytes=%h",
             tag, lane_bytes(obs), lane_bytes(exp));
    end
  endtask

  task automatic run_word(input string tag, input logic [63:0] in_nib, input logic [NL-1:0] sh,
                          input logic [GW-1:0] gs, input logic [63:0] exp_nib, input logic exp_err);
    in_w     = mk_word(in_nib);
    shift    = sh;
    gsize    = gs;
    in_valid = 1'b1;
    #1;
    check_bit({tag, ".in_ready"}, in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    scramble_in();
    shift    = NL'($urandom());
    check_bit({tag, ".err"}, err, exp_err);
    tick();
    check_bit({tag, ".err_clear"}, err, 1'b0);
    check_bit({tag, ".valid_t1"}, out_valid, 1'b0);
    tick();
    check_bit({tag, ".valid_t2"}, out_valid, 1'b0);
    tick();
    check_bit({tag, ".valid_t3"}, out_valid, 1'b1);
    check_word({tag, ".out"}, out_w, mk_word(exp_nib));
    tick();
    check_bit({tag, ".valid_done"}, out_valid, 1'b0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int sent;
    int recv;
    int cyc;

    // Reset with garbage offered on the input.
    rst       = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    scramble_in();
    shift     = 4'd3;
    gsize     = 5'd0;
    repeat (3) tick();
    check_bit("rst.out_valid", out_valid, 1'b0);
    check_bit("rst.err", err, 1'b0);
    check_bit("rst.in_ready", in_ready, 1'b1);
    check_word("rst.out", out_w, '0);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check_bit("post_rst.in_ready", in_ready, 1'b1);

    // Single words through the pipeline, legal and illegal group sizes.
    run_word("g16s3",  64'hCBA9_8765_4321_0FED, 4'd3,  5'd16, ID_NIB,                 1'b0);
    run_word("g4s5",   ID_NIB,                  4'd5,  5'd4,  64'hCFED_8BA9_4765_0321, 1'b0);
    run_word("g2s3",   ID_NIB,                  4'd3,  5'd2,  64'hEFCD_AB89_6745_2301, 1'b0);
    run_word("g8s6",   ID_NIB,                  4'd6,  5'd8,  64'hDCBA_98FE_5432_1076, 1'b0);
    run_word("g1s7",   ID_NIB,                  4'd7,  5'd1,  ID_NIB,                 1'b0);
    run_word("g16s15", ID_NIB,                  4'd15, 5'd16, 64'hEDCB_A987_6543_210F, 1'b0);
    run_word("g5s2",   ID_NIB,                  4'd2,  5'd5,  64'h10FE_DCBA_9876_5432, 1'b1);
    run_word("g0s1",   ID_NIB,                  4'd1,  5'd0,  64'h0FED_CBA9_8765_4321, 1'b1);
    run_word("g20s2",  ID_NIB,                  4'd2,  5'd20, 64'h10FE_DCBA_9876_5432, 1'b1);

    // Eight-word stream with a five-cycle consumer stall in the middle.
    sent = 0;
    recv = 0;
    cyc  = 0;
    while (recv < 8 && cyc < 80) begin
      out_ready = !(cyc >= 6 && cyc <= 10);
      if (sent < 8) begin
        in_valid = 1'b1;
        in_w     = stream_in(sent);
        shift    = NL'(sent);
        gsize    = 5'd16;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (!out_ready) begin
        check_bit("stall.in_ready", in_ready, 1'b0);
        check_bit("stall.out_valid", out_valid, 1'b1);
        check_word("stall.out", out_w, stream_exp(recv));
      end else if (out_valid) begin
        check_word($sformatf("stream.word%0d", recv), out_w, stream_exp(recv));
        recv++;
      end
      if (in_valid && in_ready) sent++;
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    assert (recv == 8) else begin
      failures++;
      $error("[TB] FAIL stream.count observed=%0d expected=8", recv);
    end
    repeat (3) begin
      tick();
      check_bit("stream.drained", out_valid, 1'b0);
    end

    // Reset while three words are in flight: none may ever surface.
    for (int n = 0; n < 3; n++) begin
      in_w     = stream_in(n);
      shift    = 4'd0;
      gsize    = 5'd16;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check_bit("flush.in_ready", in_ready, 1'b1);
    tick();
    rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick();
      check_bit($sformatf("flush.quiet%0d", n), out_valid, 1'b0);
    end
    run_word("post_flush", 64'hCBA9_8765_4321_0FED, 4'd3, 5'd16, ID_NIB, 1'b0);

    // Held output, then an asynchronous reset between clock edges.
    out_ready = 1'b0;
    in_w      = mk_word(ID_NIB);
    shift     = 4'd1;
    gsize     = 5'd16;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check_bit("hold.valid", out_valid, 1'b1);
    tick();
    check_bit("hold.valid_kept", out_valid, 1'b1);
    check_word("hold.out", out_w, mk_word(64'h0FED_CBA9_8765_4321));
    check_bit("hold.in_ready", in_ready, 1'b0);
    rst = 1'b1;
    #2;
    check_bit("async.out_valid", out_valid, 1'b0);
    check_word("async.out", out_w, '0);
    check_bit("async.in_ready", in_ready, 1'b1);
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    tick();
    check_bit("async.quiet", out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
